// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register pending (scoreboard) bit for RAW/WAW stall detection.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  output logic                     issue_ready,
  input  logic [NUM_WR-1:0]        wb_valid,
  input  logic [NUM_WR*AW-1:0]     wb_addr,
  input  logic [NUM_WR*XLEN-1:0]   wb_data,
  output logic [AW:0]              busy_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_issue_busy;

  // Address maps to a real, writable register (excludes hardwired zero and out-of-range).
  function automatic logic f_wr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    w_clr = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wb_valid[w] && f_wr_ok(wb_addr[w*AW +: AW]))
        w_clr[wb_addr[w*AW +: AW]] = 1'b1;
    end

    w_issue_busy = 1'b0;
    if (f_wr_ok(issue_rd)) begin
`ifdef REGFILE_BYPASS_EN
      w_issue_busy = r_busy[issue_rd] && !w_clr[issue_rd];
`else
      w_issue_busy = r_busy[issue_rd];
`endif
    end

    w_set = '0;
    if (issue_valid && !w_issue_busy && f_wr_ok(issue_rd))
      w_set[issue_rd] = 1'b1;

    // Set is applied after clear so an issue and writeback to the same register leave it pending.
    w_busy_nxt = (r_busy & ~w_clr) | w_set;

    w_cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++)
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
  end

  assign issue_ready = !w_issue_busy;
  assign busy_cnt    = r_busy_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        r_regs[r] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest index wins on collisions.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wb_valid[w] && f_wr_ok(wb_addr[w*AW +: AW]))
          r_regs[wb_addr[w*AW +: AW]] <= wb_data[w*XLEN +: XLEN];
      end
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    logic [AW-1:0] v_a;
    rd_data = '0;
    rd_busy = '0;
    v_a     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      v_a = rd_addr[p*AW +: AW];
      if (f_wr_ok(v_a)) begin
        rd_data[p*XLEN +: XLEN] = r_regs[v_a];
        rd_busy[p]              = r_busy[v_a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wb_valid[w] && (wb_addr[w*AW +: AW] == v_a)) begin
            rd_data[p*XLEN +: XLEN] = wb_data[w*XLEN +: XLEN];
            rd_busy[p]              = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus random bench for regfile_scoreboard against an array-based reference model.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_scoreboard;
  localparam int XLEN     = 32;
  localparam int NREGS    = 24;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int ZERO_REG = 1;
  localparam int AW       = $clog2(NREGS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   issue_ready;
  logic [NUM_WR-1:0]      wb_valid;
  logic [NUM_WR*AW-1:0]   wb_addr;
  logic [NUM_WR*XLEN-1:0] wb_data;
  logic [AW:0]            busy_cnt;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy_cnt(busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wr_ok(input int a);
    return (a < NREGS) && !((ZERO_REG != 0) && (a == 0));
  endfunction

  // Highest-index same-cycle writer of address a visible to reads, or -1.
  function automatic int fwd_port(input int a);
    int hit = -1;
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (wb_valid[w] && m_wr_ok(a) && (int'(wb_addr[w*AW +: AW]) == a)) hit = w;
`endif
    return hit;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a);
    int f;
    if (!m_wr_ok(a)) return '0;
    f = fwd_port(a);
    if (f >= 0) return wb_data[f*XLEN +: XLEN];
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (!m_wr_ok(a)) return 1'b0;
    if (fwd_port(a) >= 0) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = '0;
    wb_addr     = '0;
    wb_data     = '0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Check combinational outputs, advance the model, cross the edge, check the count.
  task automatic cycle();
    bit rdy;
    int a;
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      chk("rd_data", 64'(rd_data[p*XLEN +: XLEN]), 64'(exp_data(a)));
      chk("rd_busy", 64'(rd_busy[p]), 64'(exp_busy(a)));
    end
    rdy = !exp_busy(int'(issue_rd));
    chk("issue_ready", 64'(issue_ready), 64'(rdy));
    for (int w = 0; w < NUM_WR; w++) begin
      a = int'(wb_addr[w*AW +: AW]);
      if (wb_valid[w] && m_wr_ok(a)) begin
        m_regs[a] = wb_data[w*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (issue_valid && rdy && m_wr_ok(int'(issue_rd))) m_busy[int'(issue_rd)] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(m_count()));
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input int a, input logic [XLEN-1:0] d, input bit b);
    rd_addr[0 +: AW] = AW'(a);
    #1;
    chk(tag, 64'(rd_data[0 +: XLEN]), 64'(d));
    chk(tag, 64'(rd_busy[0]), 64'(b));
  endtask

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    idle();
    model_clear();
    #1;
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_rd_busy", 64'(rd_busy), 64'(0));
    chk("rst_ready", 64'(issue_ready), 64'(1));
    chk("rst_busy_cnt", 64'(busy_cnt), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic write, then read next cycle; writes to r0 dropped.
    wb_valid = 2'b01; wb_addr[0 +: AW] = 5'd5; wb_data[0 +: XLEN] = 32'h1234; rd_addr[0 +: AW] = 5'd5;
    cycle();
    idle();
    peek("wr_r5", 5, 32'h1234, 1'b0);
    wb_valid = 2'b01; wb_addr[0 +: AW] = 5'd0; wb_data[0 +: XLEN] = 32'hFFFF;
    cycle();
    idle();
    peek("wr_r0", 0, 32'h0, 1'b0);

    // Same-cycle collision: port 1 wins.
    wb_valid = 2'b11;
    wb_addr  = {5'd7, 5'd7};
    wb_data  = {32'h5555, 32'hAAAA};
    cycle();
    idle();
    peek("collide_r7", 7, 32'h5555, 1'b0);

    // Issue, WAW re-issue blocked, writeback clears.
    issue_valid = 1'b1; issue_rd = 5'd3; rd_addr[0 +: AW] = 5'd3;
    cycle();
    idle();
    peek("issue_r3", 3, 32'h0, 1'b1);
    chk("cnt_after_issue", 64'(busy_cnt), 64'(1));
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    chk("waw_ready", 64'(issue_ready), 64'(0));
    cycle();
    chk("cnt_after_waw", 64'(busy_cnt), 64'(1));
    idle();
    wb_valid = 2'b01; wb_addr[0 +: AW] = 5'd3; wb_data[0 +: XLEN] = 32'h10;
    cycle();
    idle();
    peek("wb_r3", 3, 32'h10, 1'b0);
    chk("cnt_after_wb", 64'(busy_cnt), 64'(0));

    // Issue and writeback to the same register on one edge: set wins.
    issue_valid = 1'b1; issue_rd = 5'd4;
    wb_valid = 2'b01; wb_addr[0 +: AW] = 5'd4; wb_data[0 +: XLEN] = 32'h44;
    cycle();
    idle();
    peek("set_wins_r4", 4, 32'h44, 1'b1);

    // Read during same-cycle writeback.
    wb_valid = 2'b01; wb_addr[0 +: AW] = 5'd9; wb_data[0 +: XLEN] = 32'h1111;
    cycle();
    wb_valid = 2'b10; wb_addr[AW +: AW] = 5'd9; wb_data[XLEN +: XLEN] = 32'hBEEF; rd_addr[0 +: AW] = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_r9", 64'(rd_data[0 +: XLEN]), 64'(32'hBEEF));
`else
    chk("same_cycle_r9", 64'(rd_data[0 +: XLEN]), 64'(32'h1111));
`endif
    cycle();
    idle();
    peek("next_cycle_r9", 9, 32'hBEEF, 1'b0);

    // Out-of-range read and issue.
    peek("oor_read", 30, 32'h0, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd31;
    cycle();
    idle();
    chk("oor_issue_cnt", 64'(busy_cnt), 64'(1));

    // Mid-run reset discards everything.
    issue_valid = 1'b1; issue_rd = 5'd12;
    cycle();
    idle();
    rst = 1'b1;
    rd_addr = {5'd12, 5'd4};
    #1;
    chk("midrst_rd_data", 64'(rd_data), 64'(0));
    chk("midrst_rd_busy", 64'(rd_busy), 64'(0));
    chk("midrst_busy_cnt", 64'(busy_cnt), 64'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic, addresses biased toward collisions and include out-of-range.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NUM_RD; p++)
        rd_addr[p*AW +: AW] = AW'($urandom_range(0, 31));
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9));
      for (int w = 0; w < NUM_WR; w++) begin
        wb_valid[w]              = ($urandom_range(0, 2) == 0);
        wb_addr[w*AW +: AW]      = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9));
        wb_data[w*XLEN +: XLEN]  = XLEN'($urandom);
      end
      cycle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
